sample2uart: RTL and testbench

Serializer stage directly downstream of the sample switch in UART mode. Accepts one 16-bit audio sample per valid/ready handshake and transmits it on a single TX line as two consecutive 8N1 UART bytes. It raises `out_ready` only when the line is idle, which paces the switch's FIFO reads.

---
 rtl/sample2uart_pkg.sv | 8 +
 rtl/uart_tx_byte.sv | 59 +++++
 rtl/sample2uart.sv | 62 ++++++
 tb/tb_sample2uart.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/sample2uart_pkg.sv
// sample2uart_pkg: FSM state encodings and baud-rate math shared by the UART-side blocks
package sample2uart_pkg;
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    function automatic int calc_cpb(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction
endpackage

// File: rtl/uart_tx_byte.sv
// uart_tx_byte: one 8N1 byte on the TX line; a start request on the final stop cycle chains the next byte gap-free
module uart_tx_byte
    import sample2uart_pkg::*;
#(
    parameter int CPB = 868
) (
    input  logic       in_clk,
    input  logic       in_rst,
    input  logic [7:0] in_byte,
    input  logic       in_start,
    output logic       out_tx,
    output logic       out_busy,
    output logic       out_byte_done
);
    localparam int CW = (CPB > 1) ? $clog2(CPB) : 1;

    state_t        state, next_state;
    logic [CW-1:0] baud_cnt;
    logic [2:0]    bit_cnt;
    logic [7:0]    shreg;
    logic          bit_end, load, tx_next;

    assign bit_end = baud_cnt == CW'(CPB - 1);
    assign load    = in_start && (state == IDLE || (state == STOP && bit_end));

    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            out_tx   <= 1'b1;
        end else begin
            state    <= next_state;
            out_tx   <= tx_next;
            baud_cnt <= (bit_end || state == IDLE) ? '0 : baud_cnt + CW'(1);
            bit_cnt  <= (state == DATA && bit_end) ? bit_cnt + 3'd1 : bit_cnt;
            if (load)
                shreg <= in_byte;
            else if (state == DATA && bit_end)
                shreg <= shreg >> 1;
        end
    end

    always_comb begin
        next_state = load ? START :
                     (state == START && bit_end) ? DATA :
                     (state == DATA && bit_end && bit_cnt == 3'd7) ? STOP :
                     (state == STOP && bit_end) ? IDLE : state;
    end

    // shreg shifts on the same edge the next data bit goes out, so look one bit ahead there
    always_comb begin
        tx_next       = (next_state == DATA) ? ((state == DATA && bit_end) ? shreg[1] : shreg[0])
                                             : (next_state != START);
        out_busy      = state != IDLE;
        out_byte_done = state == STOP && bit_end;
    end
endmodule

// File: rtl/sample2uart.sv
// sample2uart: sends each accepted 16-bit sample as two back-to-back 8N1 UART bytes
module sample2uart
    import sample2uart_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 100_000_000,
    parameter int BAUD        = 115_200,
    parameter int MSB_FIRST   = 1
) (
    input  logic        in_clk,
    input  logic        in_rst,
    input  logic [15:0] in_sample,
    input  logic        in_sample_en,
    output logic        out_ready,
    output logic        out_tx,
    output logic        out_done
);
    localparam int CPB = calc_cpb(CLK_FREQ_HZ, BAUD);

    generate
        if (CPB < 2) begin : g_cpb_check
            $error("sample2uart: CLK_FREQ_HZ / BAUD must be at least 2");
        end
    endgenerate

    logic [15:0] sample_q;
    logic [7:0]  tx_byte;
    logic        byte_idx, busy, byte_done, accept, next_byte, start;

    // the first byte comes straight from in_sample so the start bit leaves on the accept edge
    always_comb begin
        accept    = out_ready && in_sample_en && !busy;
        next_byte = byte_done && !byte_idx;
        start     = accept || next_byte;
        tx_byte   = accept ? ((MSB_FIRST != 0) ? in_sample[15:8] : in_sample[7:0])
                           : ((MSB_FIRST != 0) ? sample_q[7:0] : sample_q[15:8]);
    end

    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            sample_q  <= '0;
            byte_idx  <= 1'b0;
            out_ready <= 1'b1;
            out_done  <= 1'b0;
        end else begin
            if (accept)
                sample_q <= in_sample;
            byte_idx  <= accept ? 1'b0 : (next_byte ? 1'b1 : byte_idx);
            out_ready <= accept ? 1'b0 : ((byte_done && byte_idx) ? 1'b1 : out_ready);
            out_done  <= byte_done && byte_idx;
        end
    end

    uart_tx_byte #(.CPB(CPB)) u_tx (
        .in_clk       (in_clk),
        .in_rst       (in_rst),
        .in_byte      (tx_byte),
        .in_start     (start),
        .out_tx       (out_tx),
        .out_busy     (busy),
        .out_byte_done(byte_done)
    );
endmodule

// File: tb/tb_sample2uart.sv
// tb_sample2uart: scoreboard bench; channel 0 sends high byte first, channel 1 low byte first
module tb_sample2uart;
    localparam int CPB = 10;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  en = 2'b00;
    logic [1:0]  ready, tx, done;
    logic [15:0] samp [2];
    int          cyc = 0;
    int          checks = 0;
    int          failures = 0;
    logic [7:0]  byte_q0 [$];
    logic [7:0]  byte_q1 [$];
    int          done_q0 [$];
    int          done_q1 [$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sample2uart #(.CLK_FREQ_HZ(1_000_000), .BAUD(100_000), .MSB_FIRST(1)) u_msb (
        .in_clk(clk), .in_rst(rst), .in_sample(samp[0]), .in_sample_en(en[0]),
        .out_ready(ready[0]), .out_tx(tx[0]), .out_done(done[0])
    );

    sample2uart #(.CLK_FREQ_HZ(1_000_000), .BAUD(100_000), .MSB_FIRST(0)) u_lsb (
        .in_clk(clk), .in_rst(rst), .in_sample(samp[1]), .in_sample_en(en[1]),
        .out_ready(ready[1]), .out_tx(tx[1]), .out_done(done[1])
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic expect_frame(input int ch, input logic [7:0] b0, input logic [7:0] b1, input int done_at);
        if (ch == 0) begin
            byte_q0.push_back(b0); byte_q0.push_back(b1); done_q0.push_back(done_at);
        end else begin
            byte_q1.push_back(b0); byte_q1.push_back(b1); done_q1.push_back(done_at);
        end
    endtask

    task automatic wait_ready(input int ch);
        for (int i = 0; i < 2000 && ready[ch] !== 1'b1; i++) @(negedge clk);
        chk("ready_timeout", ready[ch], 1);
    endtask

    task automatic issue(input int ch, input logic [15:0] s);
        wait_ready(ch);
        samp[ch] = s;
        en[ch] = 1'b1;
        @(negedge clk);
        en[ch] = 1'b0;
        chk("start_bit_latency", tx[ch], 0);
        chk("ready_drop", ready[ch], 0);
    endtask

    task automatic send(input int ch, input logic [15:0] s, input logic [7:0] b0, input logic [7:0] b1);
        issue(ch, s);
        expect_frame(ch, b0, b1, cyc + 20 * CPB);
    endtask

    // decode one byte per falling start edge, sampling each bit at its centre
    task automatic line_monitor(input int ch);
        logic [9:0] fr;
        logic [7:0] e;
        bit         ab, have;
        forever begin
            @(negedge clk);
            if (tx[ch] === 1'b0 && !rst) begin
                ab = 0;
                fr = '0;
                for (int t = 1; t <= CPB * 9 + CPB / 2; t++) begin
                    @(negedge clk);
                    if (rst) ab = 1;
                    if (t >= CPB / 2 && (t - CPB / 2) % CPB == 0) fr[(t - CPB / 2) / CPB] = tx[ch];
                end
                if (!ab) begin
                    have = (ch == 0) ? (byte_q0.size() > 0) : (byte_q1.size() > 0);
                    if (!have) begin
                        chk("unexpected_byte", {22'd0, fr}, 32'hFFFFFFFF);
                    end else begin
                        e = (ch == 0) ? byte_q0.pop_front() : byte_q1.pop_front();
                        chk(ch == 0 ? "frame_msb_ch" : "frame_lsb_ch", {22'd0, fr}, {22'd0, 1'b1, e, 1'b0});
                    end
                end
            end
        end
    endtask

    initial line_monitor(0);
    initial line_monitor(1);

    initial begin
        int e;
        forever begin
            @(negedge clk);
            for (int ch = 0; ch < 2; ch++) begin
                if (done[ch] === 1'b1) begin
                    if ((ch == 0 ? done_q0.size() : done_q1.size()) == 0) begin
                        chk("unexpected_done", cyc, 32'hFFFFFFFF);
                    end else begin
                        e = (ch == 0) ? done_q0.pop_front() : done_q1.pop_front();
                        chk("done_cycle", cyc, e);
                        chk("ready_with_done", ready[ch], 1);
                    end
                end
            end
        end
    end

    initial begin
        int k, bad;
        samp[0] = '0;
        samp[1] = '0;
        repeat (3) @(negedge clk);
        chk("reset_tx", tx, 2'b11);
        chk("reset_ready", ready, 2'b11);
        chk("reset_done", done, 2'b00);
        rst = 1'b0;

        bad = 0;
        repeat (100) begin
            @(negedge clk);
            if (tx !== 2'b11 || done !== 2'b00 || ready !== 2'b11) bad++;
        end
        chk("idle_quiet", bad, 0);

        send(0, 16'hA55A, 8'hA5, 8'h5A);
        wait_ready(0);

        // continuous request: second frame starts one cycle after the first completes
        wait_ready(0);
        samp[0] = 16'h0001;
        en[0] = 1'b1;
        @(negedge clk);
        k = cyc;
        chk("b2b_first_start", tx[0], 0);
        expect_frame(0, 8'h00, 8'h01, k + 200);
        samp[0] = 16'hFFFF;
        repeat (199) @(negedge clk);
        chk("b2b_ready_before_end", ready[0], 0);
        @(negedge clk);
        chk("b2b_gap_idle", tx[0], 1);
        chk("b2b_gap_ready", ready[0], 1);
        @(negedge clk);
        chk("b2b_second_start", tx[0], 0);
        chk("b2b_second_ready", ready[0], 0);
        expect_frame(0, 8'hFF, 8'hFF, k + 401);
        en[0] = 1'b0;
        wait_ready(0);

        send(0, 16'h3C81, 8'h3C, 8'h81);
        repeat (49) @(negedge clk);
        samp[0] = 16'h1234;
        en[0] = 1'b1;
        @(negedge clk);
        en[0] = 1'b0;
        chk("busy_request_ignored", ready[0], 0);
        wait_ready(0);

        // aborted frame: no expectation queued for it
        issue(0, 16'h0000);
        repeat (44) @(negedge clk);
        chk("pre_reset_line", tx[0], 0);
        rst = 1'b1;
        #1;
        chk("async_reset_tx", tx[0], 1);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("post_reset_ready", ready[0], 1);
        chk("post_reset_done", done[0], 0);
        repeat (120) @(negedge clk);
        send(0, 16'h00FF, 8'h00, 8'hFF);
        wait_ready(0);

        send(1, 16'hBEEF, 8'hEF, 8'hBE);
        wait_ready(1);

        repeat (20) @(negedge clk);
        chk("bytes_outstanding", byte_q0.size() + byte_q1.size(), 0);
        chk("dones_outstanding", done_q0.size() + done_q1.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
